// File: rtl/ddr_tx_pkg.sv
// Shared types and helpers for the DDR transmit sequencer.
package ddr_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef logic [1:0] bit_pair_t;

    function automatic int beats(input int data_w);
        return data_w / 2;
    endfunction

endpackage

// File: rtl/ddr_tx_ctrl.sv
// Word-to-bit-pair sequencer feeding a 2-bit-per-clock DDR output cell.
// Handshakes DATA_W-bit words in and emits one bit pair per clock, gaplessly when chained.
module ddr_tx_ctrl
    import ddr_tx_pkg::*;
#(
    parameter int        DATA_W    = 16,
    parameter bit        LSB_FIRST = 1'b0,
    parameter bit_pair_t IDLE_PAT  = 2'b00
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [1:0]        ddr_o,
    output logic              frame_o,
    output logic              busy_o,
    output logic              underrun_o
);

    localparam int BEATS = beats(DATA_W);
    localparam int CNT_W = $clog2(BEATS);

    if ((DATA_W % 2) != 0 || DATA_W < 4) begin : g_bad_width
        $error("ddr_tx_ctrl: DATA_W must be even and >= 4");
    end

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  beat;
    logic [DATA_W-1:0] shreg;
    bit_pair_t         ddr_q;
    logic              frame_q;
    logic              underrun_q;
    logic              chained_q;
    logic              valid_q;
    logic              last_beat;
    logic              ready;
    logic              accept;

    // Bit pair for the head of a word, and the word advanced past that pair.
    function automatic bit_pair_t head_pair(input logic [DATA_W-1:0] w);
        if (LSB_FIRST) return {w[1], w[0]};
        else           return {w[DATA_W-2], w[DATA_W-1]};
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        if (LSB_FIRST) return w >> 2;
        else           return w << 2;
    endfunction

    assign last_beat = (beat == CNT_W'(BEATS - 1));
    assign accept    = valid_i & ready;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)                state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_beat && !accept)  state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready  = en_i & ((state == ST_IDLE) | ((state == ST_SHIFT) & last_beat));
        busy_o = (state == ST_SHIFT);
    end

    // The beat counter tracks the pair currently visible on ddr_o.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            beat       <= '0;
            shreg      <= '0;
            ddr_q      <= IDLE_PAT;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
            chained_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q    <= valid_i;
            underrun_q <= (state == ST_SHIFT) & last_beat & en_i & ~accept
                          & (chained_q | valid_q);
            if (accept) begin
                shreg     <= advance(data_i);
                ddr_q     <= head_pair(data_i);
                frame_q   <= 1'b1;
                beat      <= '0;
                chained_q <= (state == ST_SHIFT);
            end else if (state == ST_SHIFT && !last_beat) begin
                shreg   <= advance(shreg);
                ddr_q   <= head_pair(shreg);
                frame_q <= 1'b1;
                beat    <= beat + CNT_W'(1);
            end else begin
                ddr_q     <= IDLE_PAT;
                frame_q   <= 1'b0;
                beat      <= '0;
                chained_q <= 1'b0;
            end
        end
    end

    assign ready_o    = ready;
    assign ddr_o      = ddr_q;
    assign frame_o    = frame_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_ddr_tx_ctrl.sv
// Randomized bench for ddr_tx_ctrl: an 8-bit MSB-first and a 16-bit LSB-first instance
// checked every cycle against a word/beat-level reference model.
module tb_ddr_tx_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i, en_i;
    logic        valid8, valid16;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic        ready8, frame8, busy8, under8;
    logic        ready16, frame16, busy16, under16;
    logic [1:0]  ddr8, ddr16;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ddr_tx_ctrl #(.DATA_W(8), .LSB_FIRST(1'b0), .IDLE_PAT(2'b00)) dut8 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data8), .valid_i(valid8),
        .ready_o(ready8), .ddr_o(ddr8), .frame_o(frame8), .busy_o(busy8), .underrun_o(under8)
    );

    ddr_tx_ctrl #(.DATA_W(16), .LSB_FIRST(1'b1), .IDLE_PAT(2'b00)) dut16 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data16), .valid_i(valid16),
        .ready_o(ready16), .ddr_o(ddr16), .frame_o(frame16), .busy_o(busy16), .underrun_o(under16)
    );

    // Reference model state: which word is on the pins and which beat of it.
    bit          act[2]   = '{0, 0};
    int          k[2]     = '{0, 0};
    logic [15:0] wrd[2]   = '{16'h0, 16'h0};
    bit          strm[2]  = '{0, 0};
    bit          vprev[2] = '{0, 0};
    bit          und[2]   = '{0, 0};
    bit          accd[2]  = '{0, 0};
    logic [1:0]  last_ddr[2];
    bit          last_und[2];
    const int    nb[2]    = '{4, 8};
    const int    wid[2]   = '{8, 16};
    const bit    lsb[2]   = '{1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_pair(input logic [15:0] w, input int kk, input int width,
                                            input bit lsb_first);
        logic d0, d1;
        if (lsb_first) begin
            d0 = w[2*kk];
            d1 = w[2*kk+1];
        end else begin
            d0 = w[width-1-2*kk];
            d1 = w[width-2-2*kk];
        end
        return {d1, d0};
    endfunction

    task automatic step(input bit rst_n, input bit en, input bit v8, input logic [7:0] d8,
                        input bit v16, input logic [15:0] d16);
        logic [1:0]  o_ddr[2];
        bit          o_frm[2], o_bsy[2], o_und[2], o_rdy[2];
        bit          vin[2];
        logic [15:0] din[2];
        bit          rdy, acc;
        @(negedge clk_i);
        o_ddr = '{ddr8, ddr16};
        o_frm = '{frame8, frame16};
        o_bsy = '{busy8, busy16};
        o_und = '{under8, under16};
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ddr%0d", wid[i]), o_ddr[i],
                  act[i] ? exp_pair(wrd[i], k[i], wid[i], lsb[i]) : 2'b00);
            check($sformatf("frame%0d", wid[i]), o_frm[i], act[i]);
            check($sformatf("busy%0d", wid[i]), o_bsy[i], act[i]);
            check($sformatf("underrun%0d", wid[i]), o_und[i], und[i]);
            last_ddr[i] = o_ddr[i];
            last_und[i] = o_und[i];
        end
        rst_n_i = rst_n; en_i = en;
        valid8 = v8;   data8 = d8;
        valid16 = v16; data16 = d16;
        vin = '{v8, v16};
        din = '{{8'h00, d8}, d16};
        #1;
        o_rdy = '{ready8, ready16};
        for (int i = 0; i < 2; i++) begin
            rdy = en && (!act[i] || k[i] == nb[i] - 1);
            check($sformatf("ready%0d", wid[i]), o_rdy[i], rdy);
            acc = vin[i] && rdy;
            accd[i] = acc && rst_n;
            if (!rst_n) begin
                act[i] = 0; k[i] = 0; strm[i] = 0; und[i] = 0; vprev[i] = 0;
            end else begin
                und[i] = act[i] && (k[i] == nb[i] - 1) && en && !acc && (strm[i] || vprev[i]);
                if (acc) begin
                    strm[i] = act[i];
                    wrd[i]  = din[i];
                    k[i]    = 0;
                    act[i]  = 1;
                end else if (act[i] && k[i] < nb[i] - 1) begin
                    k[i]++;
                end else begin
                    act[i]  = 0;
                    strm[i] = 0;
                end
                vprev[i] = vin[i];
            end
        end
    endtask

    initial begin
        automatic bit         rv8 = 0, rv16 = 0;
        automatic logic [7:0] rd8 = '0;
        automatic logic [15:0] rd16 = '0;
        automatic int         pulses;
        automatic logic [1:0] a5_exp[5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00};

        rst_n_i = 1'b0; en_i = 1'b0; valid8 = 1'b0; valid16 = 1'b0; data8 = '0; data16 = '0;
        repeat (2) @(posedge clk_i);
        step(0, 0, 0, 8'h00, 0, 16'h0000);
        step(1, 1, 0, 8'h00, 0, 16'h0000);

        // Single word A5 on the 8-bit lane, 0001 on the 16-bit LSB-first lane.
        step(1, 1, 1, 8'hA5, 1, 16'h0001);
        for (int c = 0; c < 5; c++) begin
            step(1, 1, 0, 8'h00, 0, 16'h0000);
            check($sformatf("a5_beat%0d", c), last_ddr[0], a5_exp[c]);
            check("a5_no_underrun", last_und[0], 1'b0);
            if (c == 0) check("lsb_first_beat0", last_ddr[1], 2'b01);
        end
        repeat (6) step(1, 1, 0, 8'h00, 0, 16'h0000);

        // Three chained words then the stream stops: exactly one underrun pulse.
        pulses = 0;
        step(1, 1, 1, 8'hFF, 0, 16'h0000);
        for (int c = 0; c < 8; c++) step(1, 1, 1, (c < 3) ? 8'hFF : 8'h00, 0, 16'h0000);
        for (int c = 0; c < 8; c++) begin
            step(1, 1, 0, 8'h00, 0, 16'h0000);
            if (last_und[0]) pulses++;
        end
        check("underrun_pulses", pulses, 1);

        // en_i dropped on beat 1 of 3C.
        step(1, 1, 1, 8'h3C, 0, 16'h0000);
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        repeat (5) step(1, 0, 1, 8'h77, 0, 16'h0000);
        step(1, 1, 0, 8'h00, 0, 16'h0000);

        // Reset asserted on beat 2, then a fresh word.
        step(1, 1, 1, 8'hC3, 1, 16'hBEEF);
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        step(0, 1, 0, 8'h00, 0, 16'h0000);
        step(1, 1, 1, 8'h96, 0, 16'h0000);
        repeat (6) step(1, 1, 0, 8'h00, 0, 16'h0000);

        // Random traffic; sources hold data until accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!rv8 || accd[0]) begin
                rv8 = ($urandom_range(0, 4) != 0);
                rd8 = 8'($urandom);
            end
            if (!rv16 || accd[1]) begin
                rv16 = ($urandom_range(0, 4) != 0);
                rd16 = 16'($urandom);
            end
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 15) != 0),
                 rv8, rd8, rv16, rd16);
        end
        repeat (10) step(1, 1, 0, 8'h00, 0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
